// File: rtl/sophiali_cmu_hex_display.sv
// sophiali_cmu_hex_display: latch an 8-bit value and show it as two multiplexed hex digits
// Ports:
//   clock       rising-edge system clock
//   reset       synchronous active-high reset
//   value_in    value to display, sampled whenever value_valid is high
//   value_valid capture strobe (last write before a frame boundary wins)
//   seg         active-high segments {g,f,e,d,c,b,a}
//   digit_sel   0 = low-nibble digit, 1 = high-nibble digit
//   update_ack  one-cycle pulse when a new value reaches the display
module sophiali_cmu_hex_display #(
    parameter int REFRESH_CYCLES = 1024,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] value_in,
    input  logic       value_valid,
    output logic [6:0] seg,
    output logic       digit_sel,
    output logic       update_ack
);
    localparam int CW = $clog2(REFRESH_CYCLES);

    logic [CW-1:0] cnt;
    logic [7:0]    disp_val;
    logic [7:0]    pend_val;
    logic          pend_flag;
    logic          wrap;
    logic          boundary;
    logic [3:0]    nib;
    logic [6:0]    hex;

    assign wrap     = cnt == CW'(REFRESH_CYCLES - 1);
    // A frame ends when the high digit finishes, so commits never split a frame.
    assign boundary = wrap && digit_sel;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            digit_sel  <= 1'b0;
            disp_val   <= 8'h00;
            pend_val   <= 8'h00;
            pend_flag  <= 1'b0;
            update_ack <= 1'b0;
        end else begin
            cnt        <= wrap ? '0 : cnt + CW'(1);
            digit_sel  <= wrap ? ~digit_sel : digit_sel;
            update_ack <= 1'b0;
            if (boundary && (pend_flag || value_valid)) begin
                // A strobe on the boundary itself bypasses the pending buffer.
                disp_val   <= value_valid ? value_in : pend_val;
                pend_flag  <= 1'b0;
                update_ack <= 1'b1;
            end else if (value_valid) begin
                pend_val  <= value_in;
                pend_flag <= 1'b1;
            end
        end
    end

    assign nib = digit_sel ? disp_val[7:4] : disp_val[3:0];

    always_comb begin
        hex = 7'h00;
        case (nib)
            4'h0: hex = 7'h3F;
            4'h1: hex = 7'h06;
            4'h2: hex = 7'h5B;
            4'h3: hex = 7'h4F;
            4'h4: hex = 7'h66;
            4'h5: hex = 7'h6D;
            4'h6: hex = 7'h7D;
            4'h7: hex = 7'h07;
            4'h8: hex = 7'h7F;
            4'h9: hex = 7'h6F;
            4'hA: hex = 7'h77;
            4'hB: hex = 7'h7C;
            4'hC: hex = 7'h39;
            4'hD: hex = 7'h5E;
            4'hE: hex = 7'h79;
            4'hF: hex = 7'h71;
            default: hex = 7'h00;
        endcase
    end

    assign seg = (BLANK_LEADING && digit_sel && disp_val[7:4] == 4'h0) ? 7'h00 : hex;
endmodule

// File: tb/tb_sophiali_cmu_hex_display.sv
// tb_sophiali_cmu_hex_display: randomized and directed check against a frame-position model
module tb_sophiali_cmu_hex_display;
    localparam int R = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       value_valid = 1'b0;
    logic [7:0] value_in = 8'h00;
    logic [6:0] seg, seg_nb;
    logic       digit_sel, digit_sel_nb, update_ack, update_ack_nb;

    int checks = 0;
    int failures = 0;

    int         t = 0;
    logic [7:0] m_disp = 8'h00;
    logic [7:0] m_pend = 8'h00;
    bit         m_has = 1'b0;
    bit         m_ack = 1'b0;
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    sophiali_cmu_hex_display #(.REFRESH_CYCLES(R), .BLANK_LEADING(1'b1)) dut (
        .clock(clock), .reset(reset), .value_in(value_in), .value_valid(value_valid),
        .seg(seg), .digit_sel(digit_sel), .update_ack(update_ack)
    );

    sophiali_cmu_hex_display #(.REFRESH_CYCLES(R), .BLANK_LEADING(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .value_in(value_in), .value_valid(value_valid),
        .seg(seg_nb), .digit_sel(digit_sel_nb), .update_ack(update_ack_nb)
    );

    always #5 clock = ~clock;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic step(bit r, bit v, logic [7:0] d);
        logic       e_dsel;
        logic [3:0] e_nib;
        logic [6:0] e_seg;
        @(negedge clock);
        reset = r;
        value_valid = v;
        value_in = d;
        @(posedge clock);
        if (r) begin
            t = 0;
            m_disp = 8'h00;
            m_pend = 8'h00;
            m_has = 1'b0;
            m_ack = 1'b0;
        end else begin
            m_ack = 1'b0;
            if (t % (2 * R) == 2 * R - 1 && (m_has || v)) begin
                m_disp = v ? d : m_pend;
                m_has = 1'b0;
                m_ack = 1'b1;
            end else if (v) begin
                m_pend = d;
                m_has = 1'b1;
            end
            t++;
        end
        #1;
        e_dsel = ((t / R) % 2) == 1;
        e_nib = e_dsel ? m_disp[7:4] : m_disp[3:0];
        e_seg = (e_dsel && m_disp[7:4] == 4'h0) ? 7'h00 : hex_tab[e_nib];
        check("seg", 32'(seg), 32'(e_seg));
        check("dsel", 32'(digit_sel), 32'(e_dsel));
        check("ack", 32'(update_ack), 32'(m_ack));
        check("seg_nb", 32'(seg_nb), 32'(hex_tab[e_nib]));
        check("dsel_nb", 32'(digit_sel_nb), 32'(e_dsel));
        check("ack_nb", 32'(update_ack_nb), 32'(m_ack));
    endtask

    initial begin
        step(1'b1, 1'b0, 8'h00);
        check("rst_seg", 32'(seg), 32'h3F);
        repeat (16) step(1'b0, 1'b0, 8'h00);
        repeat (2) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hA7);
        repeat (16) step(1'b0, 1'b0, 8'h00);
        while (t % (2 * R) != 1) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h12);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h3C);
        repeat (16) step(1'b0, 1'b0, 8'h00);
        while (t % (2 * R) != 2 * R - 1) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hF0);
        check("bypass_ack", 32'(update_ack), 32'h1);
        check("bypass_seg", 32'(seg), 32'h3F);
        repeat (8) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h05);
        repeat (16) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        repeat (16) step(1'b0, 1'b0, 8'h00);
        while ((t / R) % 2 != 1) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h55);
        check("midrst_seg", 32'(seg), 32'h3F);
        repeat (12) step(1'b0, 1'b0, 8'h00);
        repeat (3000) step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, 8'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
